// File: rtl/npu_cfg_pkg.sv
// Shared opcode map, default widths and opcode classification for the NPU
// config dispatch slice.
package npu_cfg_pkg;

  localparam int unsigned DEF_N_PE       = 8;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_OP_W       = 10;
  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_RST_PULSE  = 4;

  localparam int unsigned OP_NOP         = 32'h000;
  localparam int unsigned OP_IN_FMT      = 32'h001;
  localparam int unsigned OP_OUT_FMT     = 32'h002;
  localparam int unsigned OP_IN_CNT      = 32'h003;
  localparam int unsigned OP_OUT_CNT     = 32'h004;
  localparam int unsigned OP_SCHED       = 32'h005;
  localparam int unsigned OP_OFFSET      = 32'h006;
  localparam int unsigned OP_SOFT_RST    = 32'h007;
  localparam int unsigned OP_WEIGHT_BASE = 32'h010;

  typedef enum logic [3:0] {
    OPK_NOP,
    OPK_IN_FMT,
    OPK_OUT_FMT,
    OPK_IN_CNT,
    OPK_OUT_CNT,
    OPK_SCHED,
    OPK_OFFSET,
    OPK_SOFT_RST,
    OPK_WEIGHT,
    OPK_ILLEGAL
  } op_kind_e;

  // Classify a zero-extended opcode; weight opcodes are legal only below n_pe.
  function automatic op_kind_e decode_op(input logic [31:0] op, input int unsigned n_pe);
    op_kind_e kind;
    kind = OPK_ILLEGAL;
    case (op)
      OP_NOP:      kind = OPK_NOP;
      OP_IN_FMT:   kind = OPK_IN_FMT;
      OP_OUT_FMT:  kind = OPK_OUT_FMT;
      OP_IN_CNT:   kind = OPK_IN_CNT;
      OP_OUT_CNT:  kind = OPK_OUT_CNT;
      OP_SCHED:    kind = OPK_SCHED;
      OP_OFFSET:   kind = OPK_OFFSET;
      OP_SOFT_RST: kind = OPK_SOFT_RST;
      default: begin
        if ((op >= OP_WEIGHT_BASE) && ((op - OP_WEIGHT_BASE) < n_pe)) begin
          kind = OPK_WEIGHT;
        end
      end
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/npu_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy count.
// Pushes while full and pops while empty are ignored.
module npu_sync_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Status derived from the registered count; qualify the requests with it.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    dout    = mem[rd_ptr];
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/npu_config_dispatch.sv
// NPU config dispatch: buffers config words, decodes one per cycle into a
// single-cycle write strobe with shared payload, and generates a timed soft
// reset pulse. Overflow and illegal-opcode events are latched until RST.
module npu_config_dispatch
  import npu_cfg_pkg::*;
#(
  parameter int unsigned N_PE       = DEF_N_PE,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned OP_W       = DEF_OP_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned RST_PULSE  = DEF_RST_PULSE
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [OP_W+DATA_W-1:0]          cfg_din,
  input  logic                            cfg_wr_en,
  input  logic                            cfg_rd_en,
  output logic [DATA_W-1:0]               cfg_dout,
  output logic                            cfg_full,
  output logic                            cfg_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] cfg_count,
  output logic [N_PE-1:0]                 weight_wr_en,
  output logic                            input_format_wr_en,
  output logic                            output_format_wr_en,
  output logic                            input_cnt_wr_en,
  output logic                            output_cnt_wr_en,
  output logic                            sched_buf_wr_en,
  output logic                            offset_buf_wr_en,
  output logic                            npu_rst,
  output logic                            cfg_overflow,
  output logic                            cfg_illegal
);

  localparam int unsigned CFG_W   = OP_W + DATA_W;
  localparam int unsigned PULSE_W = $clog2(RST_PULSE + 1);

  logic [CFG_W-1:0]   fifo_dout;
  logic               pop_go;
  logic               busy;
  logic [31:0]        op_ext;
  logic [31:0]        w_idx;
  op_kind_e           op_kind;
  logic [N_PE-1:0]    w_next;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [PULSE_W-1:0] pulse_next;

  npu_sync_fifo #(
    .WIDTH (CFG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (cfg_wr_en),
    .pop   (pop_go),
    .din   (cfg_din),
    .dout  (fifo_dout),
    .full  (cfg_full),
    .empty (cfg_empty),
    .count (cfg_count)
  );

  // Decode the head-of-FIFO word and decide whether it is popped this cycle.
  always_comb begin
    busy    = (pulse_cnt != '0);
    pop_go  = cfg_rd_en && !cfg_empty && !busy;
    op_ext  = 32'(fifo_dout[CFG_W-1:DATA_W]);
    w_idx   = op_ext - OP_WEIGHT_BASE;
    op_kind = decode_op(op_ext, N_PE);
  end

  // Next weight strobe vector and next soft-reset pulse count.
  always_comb begin
    w_next = '0;
    for (int unsigned k = 0; k < N_PE; k++) begin
      w_next[k] = pop_go && (op_kind == OPK_WEIGHT) && (w_idx == k);
    end
    if (pop_go && (op_kind == OPK_SOFT_RST)) begin
      pulse_next = PULSE_W'(RST_PULSE);
    end else if (pulse_cnt != '0) begin
      pulse_next = pulse_cnt - PULSE_W'(1);
    end else begin
      pulse_next = pulse_cnt;
    end
  end

  // Output strobes, payload, pulse counter and sticky flags.
  // npu_rst is registered from pulse_next so it drops on the first edge after
  // RST release and stays high exactly RST_PULSE cycles after a SOFT_RST pop.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cfg_dout            <= '0;
      weight_wr_en        <= '0;
      input_format_wr_en  <= 1'b0;
      output_format_wr_en <= 1'b0;
      input_cnt_wr_en     <= 1'b0;
      output_cnt_wr_en    <= 1'b0;
      sched_buf_wr_en     <= 1'b0;
      offset_buf_wr_en    <= 1'b0;
      pulse_cnt           <= '0;
      npu_rst             <= 1'b1;
      cfg_overflow        <= 1'b0;
      cfg_illegal         <= 1'b0;
    end else begin
      weight_wr_en        <= w_next;
      input_format_wr_en  <= pop_go && (op_kind == OPK_IN_FMT);
      output_format_wr_en <= pop_go && (op_kind == OPK_OUT_FMT);
      input_cnt_wr_en     <= pop_go && (op_kind == OPK_IN_CNT);
      output_cnt_wr_en    <= pop_go && (op_kind == OPK_OUT_CNT);
      sched_buf_wr_en     <= pop_go && (op_kind == OPK_SCHED);
      offset_buf_wr_en    <= pop_go && (op_kind == OPK_OFFSET);
      if (pop_go && (op_kind != OPK_ILLEGAL)) begin
        cfg_dout <= fifo_dout[DATA_W-1:0];
      end
      pulse_cnt <= pulse_next;
      npu_rst   <= (pulse_next != '0);
      if (cfg_wr_en && cfg_full) begin
        cfg_overflow <= 1'b1;
      end
      if (pop_go && (op_kind == OPK_ILLEGAL)) begin
        cfg_illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_config_dispatch.sv
// Self-checking bench for npu_config_dispatch: table-driven opcode vectors,
// a dispatch scoreboard checked every cycle, and hand-written corner cases.
module tb_npu_config_dispatch;

  logic        CLK;
  logic        RST;
  logic [25:0] cfg_din;
  logic        cfg_wr_en;
  logic        cfg_rd_en;
  logic [15:0] cfg_dout;
  logic        cfg_full;
  logic        cfg_empty;
  logic [4:0]  cfg_count;
  logic [7:0]  weight_wr_en;
  logic        input_format_wr_en;
  logic        output_format_wr_en;
  logic        input_cnt_wr_en;
  logic        output_cnt_wr_en;
  logic        sched_buf_wr_en;
  logic        offset_buf_wr_en;
  logic        npu_rst;
  logic        cfg_overflow;
  logic        cfg_illegal;

  npu_config_dispatch #(
    .N_PE       (8),
    .DATA_W     (16),
    .OP_W       (10),
    .FIFO_DEPTH (16),
    .RST_PULSE  (4)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .cfg_din             (cfg_din),
    .cfg_wr_en           (cfg_wr_en),
    .cfg_rd_en           (cfg_rd_en),
    .cfg_dout            (cfg_dout),
    .cfg_full            (cfg_full),
    .cfg_empty           (cfg_empty),
    .cfg_count           (cfg_count),
    .weight_wr_en        (weight_wr_en),
    .input_format_wr_en  (input_format_wr_en),
    .output_format_wr_en (output_format_wr_en),
    .input_cnt_wr_en     (input_cnt_wr_en),
    .output_cnt_wr_en    (output_cnt_wr_en),
    .sched_buf_wr_en     (sched_buf_wr_en),
    .offset_buf_wr_en    (offset_buf_wr_en),
    .npu_rst             (npu_rst),
    .cfg_overflow        (cfg_overflow),
    .cfg_illegal         (cfg_illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Strobe bits: [13:6] weight k, 5 offset, 4 sched, 3 out_cnt, 2 in_cnt, 1 out_fmt, 0 in_fmt
  typedef struct {
    logic [9:0]  op;
    logic [15:0] d;
    logic [13:0] st;
  } vec_t;

  typedef struct {
    logic [13:0] st;
    logic [15:0] d;
  } sb_t;

  sb_t         sb[$];
  int unsigned n_cmp  = 0;
  int unsigned n_err  = 0;
  int unsigned rst_hi = 0;

  function automatic logic [13:0] strobes();
    return {weight_wr_en, offset_buf_wr_en, sched_buf_wr_en, output_cnt_wr_en,
            input_cnt_wr_en, output_format_wr_en, input_format_wr_en};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_dispatch(input logic [13:0] st, input logic [15:0] d);
    sb_t e;
    e.st = st;
    e.d  = d;
    sb.push_back(e);
  endtask

  // Advance one cycle and check any dispatch against the scoreboard.
  task automatic tick();
    logic [13:0] s;
    sb_t         e;
    @(posedge CLK);
    @(negedge CLK);
    if (!RST) begin
      s = strobes();
      if (npu_rst) rst_hi++;
      if (s != '0) begin
        chk("strobe_in_npu_rst", 32'(npu_rst), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 32'(s), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_strobe", 32'(s), 32'(e.st));
          chk("sb_data", 32'(cfg_dout), 32'(e.d));
        end
      end
    end
  endtask

  task automatic drain(input int unsigned max_cyc);
    int unsigned n;
    n = 0;
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b1;
    while (!cfg_empty && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_done", 32'(cfg_empty), 32'd1);
    tick();
    tick();
    chk("sb_left", 32'(sb.size()), 32'd0);
    cfg_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[10];
    logic [13:0] st;

    tbl[0] = '{10'h000, 16'h1234, 14'h0000};
    tbl[1] = '{10'h001, 16'h0101, 14'h0001};
    tbl[2] = '{10'h002, 16'h0202, 14'h0002};
    tbl[3] = '{10'h003, 16'h0303, 14'h0004};
    tbl[4] = '{10'h004, 16'h0404, 14'h0008};
    tbl[5] = '{10'h005, 16'h0505, 14'h0010};
    tbl[6] = '{10'h006, 16'h0606, 14'h0020};
    tbl[7] = '{10'h010, 16'hA0A0, 14'h0040};
    tbl[8] = '{10'h013, 16'hBEEF, 14'h0200};
    tbl[9] = '{10'h017, 16'h7777, 14'h2000};

    RST       = 1'b1;
    cfg_din   = '0;
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b0;

    // Reset state
    #1;
    chk("rst_npu_rst", 32'(npu_rst), 32'd1);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_empty", 32'(cfg_empty), 32'd1);
    tick();
    tick();
    chk("rst_full", 32'(cfg_full), 32'd0);
    chk("rst_count", 32'(cfg_count), 32'd0);
    chk("rst_dout", 32'(cfg_dout), 32'd0);
    chk("rst_overflow", 32'(cfg_overflow), 32'd0);
    chk("rst_illegal", 32'(cfg_illegal), 32'd0);
    RST = 1'b0;
    #1;
    chk("rel_npu_rst_held", 32'(npu_rst), 32'd1);
    tick();
    chk("rel_npu_rst_low", 32'(npu_rst), 32'd0);

    // Single weight dispatch with exact latency
    cfg_din   = {10'h013, 16'hBEEF};
    cfg_wr_en = 1'b1;
    cfg_rd_en = 1'b1;
    expect_dispatch(14'h0200, 16'hBEEF);
    tick();
    chk("lat_no_early_strobe", 32'(strobes()), 32'd0);
    cfg_wr_en = 1'b0;
    tick();
    chk("lat_weight", 32'(weight_wr_en), 32'h08);
    chk("lat_dout", 32'(cfg_dout), 32'hBEEF);
    tick();
    chk("lat_weight_off", 32'(weight_wr_en), 32'h00);
    chk("lat_dout_hold", 32'(cfg_dout), 32'hBEEF);
    cfg_rd_en = 1'b0;

    // Table of every legal opcode class
    for (int i = 0; i < 10; i++) begin
      cfg_din   = {tbl[i].op, tbl[i].d};
      cfg_wr_en = 1'b1;
      if (tbl[i].st != '0) expect_dispatch(tbl[i].st, tbl[i].d);
      tick();
    end
    cfg_wr_en = 1'b0;
    chk("tbl_count", 32'(cfg_count), 32'd10);
    drain(30);

    // Overflow: 17 pushes into 16 entries, then ordered drain
    for (int i = 0; i < 17; i++) begin
      cfg_din   = {10'h010 + 10'(i % 8), 16'hA000 + 16'(i)};
      cfg_wr_en = 1'b1;
      if (i < 16) begin
        st = 14'h0040 << (i % 8);
        expect_dispatch(st, 16'hA000 + 16'(i));
      end
      if (i == 16) chk("ovf_not_yet", 32'(cfg_overflow), 32'd0);
      tick();
    end
    cfg_wr_en = 1'b0;
    chk("ovf_full", 32'(cfg_full), 32'd1);
    chk("ovf_count", 32'(cfg_count), 32'd16);
    chk("ovf_flag", 32'(cfg_overflow), 32'd1);
    drain(40);
    chk("ovf_empty_after", 32'(cfg_empty), 32'd1);

    // Soft reset pulse, following word survives
    rst_hi    = 0;
    cfg_din   = {10'h007, 16'h0000};
    cfg_wr_en = 1'b1;
    tick();
    cfg_din = {10'h001, 16'h0042};
    expect_dispatch(14'h0001, 16'h0042);
    tick();
    drain(40);
    chk("soft_rst_len", 32'(rst_hi), 32'd4);
    chk("soft_dout", 32'(cfg_dout), 32'h0042);
    chk("ovf_sticky", 32'(cfg_overflow), 32'd1);

    // Illegal opcodes
    chk("ill_before", 32'(cfg_illegal), 32'd0);
    cfg_din   = {10'h018, 16'h1111};
    cfg_wr_en = 1'b1;
    tick();
    cfg_din = {10'h3FF, 16'h0000};
    tick();
    drain(20);
    chk("ill_flag", 32'(cfg_illegal), 32'd1);
    chk("ill_count", 32'(cfg_count), 32'd0);

    // Steady state: simultaneous push and pop at count 8
    cfg_rd_en = 1'b0;
    for (int i = 0; i < 28; i++) begin
      cfg_din   = {10'h010 + 10'(i % 8), 16'hC000 + 16'(i)};
      cfg_wr_en = 1'b1;
      st = 14'h0040 << (i % 8);
      expect_dispatch(st, 16'hC000 + 16'(i));
      if (i >= 8) cfg_rd_en = 1'b1;
      tick();
      if (i >= 8) chk("steady_count", 32'(cfg_count), 32'd8);
    end
    cfg_wr_en = 1'b0;
    drain(30);

    // RST asserted mid-stream
    cfg_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cfg_din   = {10'h002, 16'hD000 + 16'(i)};
      cfg_wr_en = 1'b1;
      expect_dispatch(14'h0002, 16'hD000 + 16'(i));
      tick();
    end
    chk("mid_illegal_set", 32'(cfg_illegal), 32'd1);
    #2;
    RST = 1'b1;
    #1;
    sb.delete();
    cfg_wr_en = 1'b0;
    cfg_rd_en = 1'b0;
    chk("mid_strobes", 32'(strobes()), 32'd0);
    chk("mid_count", 32'(cfg_count), 32'd0);
    chk("mid_empty", 32'(cfg_empty), 32'd1);
    chk("mid_npu_rst", 32'(npu_rst), 32'd1);
    chk("mid_overflow", 32'(cfg_overflow), 32'd0);
    chk("mid_illegal", 32'(cfg_illegal), 32'd0);
    chk("mid_dout", 32'(cfg_dout), 32'd0);
    tick();
    tick();
    RST = 1'b0;
    #1;
    chk("mid_rel_held", 32'(npu_rst), 32'd1);
    tick();
    chk("mid_rel_low", 32'(npu_rst), 32'd0);
    chk("mid_rel_empty", 32'(cfg_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
